quad_encoder_array: RTL and testbench
=====================================

# quad_encoder_array

Parametrised multi-channel quadrature encoder interface for the FPGA fabric of the SoC. It is the successor to the fixed two-encoder motor module input. Each channel synchronises and glitch-filters one A/B pair, then decodes x4 quadrature into a signed position counter and a windowed velocity value. All channels share one Avalon-MM slave, so the HPS can read, preset and clear them.

## Interface
- NUM_CH, 2: number of encoder channels (1–16).
- CNT_W, 32: position/velocity counter width (8–32); narrower values are sign-extended on reads.
- FILT_LEN, 4: consecutive stable cycles an input must hold before it is accepted (1–255).
- VEL_DIV, 50000: velocity window length in clk cycles (1 ms at 50 MHz).
- Derived: ADDR_W = clog2(NUM_CH)+2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enc_in  in  2*NUM_CH  raw encoder pins; bit 2i = A, bit 2i+1 = B of channel i; asynchronous inputs.
- avs_address  in  ADDR_W  word address; the channel is address[ADDR_W-1:2], the register is address[1:0].
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- dir_out  out  NUM_CH  last accepted count direction per channel (1 = up), for the drive-status LEDs.
- err_irq  out  1  OR of all enabled sticky error bits.

## Operation
- Per-channel registers:
  - 0 POS: signed position, read/write. A write presets the position.
  - 1 VEL: signed count of steps over the last completed window, read-only.
  - 2 STAT: bit0 dir, bit1 illegal-transition error (sticky), bit2 wrap/overflow (sticky). Writing 1 to bit1 or bit2 clears that bit.
  - 3 CTRL: bit0 enable (reset 1), bit1 invert direction (reset 0), bit2 error IRQ enable (reset 0).
- Input path: a 2-FF synchroniser per pin feeds a filter. Each pin's filter counts consecutive cycles in which the synchronised value differs from the accepted value. At FILT_LEN the accepted value updates and the counter clears. Any return to the accepted value clears the counter.
- Decoder: compares the previous accepted AB with the new accepted AB.
  - Gray sequence 00→01→11→10→00 gives +1; the reverse sequence gives −1. Invert swaps the sign.
  - A change of both bits in one step sets STAT.bit1 and does not count.
  - When CTRL.enable=0, the decoder still tracks AB but does not count.
- Counter: wraps modulo 2^CNT_W. A wrap from max positive to min negative, or the reverse, sets STAT.bit2.
- Velocity: a shared window timer counts 0..VEL_DIV-1. On the terminal count, every channel loads VEL ← POS − snap and then snap ← POS, with the subtraction taken modulo 2^CNT_W.
- Simultaneous events:
  - A POS write and a count step in the same cycle: the write wins, and snap is also loaded with the written value.
  - A STAT clear and a new error in the same cycle: the bit stays set.
  - A POS write on a window terminal-count cycle: VEL loads normally from the pre-write POS.
- Reads of unmapped channels (channel index ≥ NUM_CH) return 0. Writes to them and to VEL are ignored.

## Timing
- Reset values: POS=0, VEL=0, snap=0, STAT=0, CTRL=0x1, avs_readdata=0, dir_out=0, err_irq=0, filters and accepted AB=00, window timer=0.
- Reset is asynchronous; asserting it mid-operation clears all state immediately, including a partially elapsed window.
- Pin to POS latency: FILT_LEN+3 cycles from the first clk edge that samples the new level (2 synchroniser cycles, FILT_LEN filter cycles, 1 decode cycle).
- Read latency: fixed at 1. avs_readdata is valid on the cycle after avs_read; there is no waitrequest.
- Writes take effect on the cycle after avs_write.
- dir_out and err_irq are registered and update one cycle after the STAT change.

## Structure
- Package quad_encoder_pkg holds:
  - register offset constants POS/VEL/STAT/CTRL;
  - STAT and CTRL bit indices;
  - a function quad_step(prev_ab, new_ab) returning {illegal, valid, up}.
- Sub-module quad_encoder_channel contains the synchroniser, filter, decoder, POS/VEL/snap/STAT/CTRL registers and a window strobe input. It is instantiated NUM_CH times with a generate loop.
- The top level holds the window timer, the Avalon address decode, the readdata mux and the err_irq reduction.

## Test plan
- Forward rotation: with NUM_CH=2, FILT_LEN=4, drive ch0 through 00,01,11,10 ×10 with each state held 8 cycles → POS=40, dir_out[0]=1, and ch1 POS=0.
- Glitch rejection: a 3-cycle pulse on ch1 A → no count. A 4-cycle stable change → +1 exactly FILT_LEN+3=7 cycles after the edge.
- Illegal transition: ch0 jumps 00→11 → POS unchanged and STAT=0x2. With CTRL=0x5, err_irq=1 on the following cycle. Writing STAT=0x2 clears the bit and err_irq.
- Wrap: with CNT_W=8, preset POS=127, then one +1 step → POS reads 0xFFFFFF80 (−128) and STAT.bit2=1. A −1 step then gives POS=127.
- Velocity: with VEL_DIV=100, apply 25 forward steps inside one window → VEL=25 after the terminal count. A POS write of 1000 mid-window followed by 5 steps → next VEL=5.
- Reset mid-operation: assert reset_n low during counting → all registers return to reset values asynchronously, and readdata is 0 on the next read.

Source files
------------

// File: rtl/quad_encoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | quad_encoder_pkg : register map, bit indices, x4 quadrature decode   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package quad_encoder_pkg;

    localparam logic [1:0] REG_POS  = 2'd0;
    localparam logic [1:0] REG_VEL  = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int STAT_DIR    = 0;
    localparam int STAT_ERR    = 1;
    localparam int STAT_WRAP   = 2;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_INV    = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam logic [2:0] CTRL_RESET = 3'b001;

    // ab = {B, A}; mapping the Gray code to a 0..3 phase makes the step the phase delta.
    function automatic logic [2:0] quad_step(input logic [1:0] prev_ab, input logic [1:0] new_ab);
        logic [1:0] prev_ph;
        logic [1:0] new_ph;
        logic [1:0] delta;
        prev_ph = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
        new_ph  = {new_ab[1], new_ab[1] ^ new_ab[0]};
        delta   = new_ph - prev_ph;
        case (delta)
            2'd1:    return 3'b011;
            2'd3:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_encoder_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | quad_encoder_channel : sync, glitch filter, decoder and registers    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module quad_encoder_channel
    import quad_encoder_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       enc,
    input  logic             win_tick,
    input  logic             pos_we,
    input  logic             stat_we,
    input  logic             ctrl_we,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] pos,
    output logic [CNT_W-1:0] vel,
    output logic [2:0]       stat,
    output logic [2:0]       ctrl
);

    localparam int               FC_W      = $clog2(FILT_LEN + 1);
    localparam logic [FC_W-1:0]  FILT_LAST = FC_W'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0] POS_MAX   = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] POS_MIN   = {1'b1, {(CNT_W-1){1'b0}}};

    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       acc;
    logic [1:0]       prev_ab;
    logic [FC_W-1:0]  fcnt [2];
    logic [CNT_W-1:0] snap;
    logic [CNT_W-1:0] pos_step;
    logic [2:0]       step;
    logic             count_en;
    logic             up_eff;
    logic             wrap_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= '0;
            sync2   <= '0;
            acc     <= '0;
            prev_ab <= '0;
            fcnt    <= '{default: '0};
        end else begin
            sync1   <= enc;
            sync2   <= sync1;
            prev_ab <= acc;
            for (int j = 0; j < 2; j++) begin
                if (sync2[j] == acc[j]) begin
                    fcnt[j] <= '0;
                end else if (fcnt[j] == FILT_LAST) begin
                    acc[j]  <= sync2[j];
                    fcnt[j] <= '0;
                end else begin
                    fcnt[j] <= fcnt[j] + FC_W'(1);
                end
            end
        end
    end

    always_comb begin
        step     = quad_step(prev_ab, acc);
        count_en = step[1] & ctrl[CTRL_EN];
        up_eff   = step[0] ^ ctrl[CTRL_INV];
        pos_step = up_eff ? pos + CNT_W'(1) : pos - CNT_W'(1);
        wrap_hit = count_en & (up_eff ? (pos == POS_MAX) : (pos == POS_MIN));
    end

    // A POS write overrides a same-cycle step; VEL still uses the pre-write POS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos  <= '0;
            vel  <= '0;
            snap <= '0;
            stat <= '0;
            ctrl <= CTRL_RESET;
        end else begin
            if (win_tick) begin
                vel <= pos - snap;
            end
            if (pos_we) begin
                pos  <= wdata;
                snap <= wdata;
            end else begin
                if (count_en) begin
                    pos            <= pos_step;
                    stat[STAT_DIR] <= up_eff;
                end
                if (win_tick) begin
                    snap <= pos;
                end
            end
            stat[STAT_ERR]  <= (stat[STAT_ERR] & ~(stat_we & wdata[STAT_ERR])) | step[2];
            stat[STAT_WRAP] <= (stat[STAT_WRAP] & ~(stat_we & wdata[STAT_WRAP])) | (wrap_hit & ~pos_we);
            if (ctrl_we) begin
                ctrl <= wdata[2:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/quad_encoder_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | quad_encoder_array : multi-channel quadrature encoder, Avalon-MM     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module quad_encoder_array
    import quad_encoder_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 4,
    parameter int VEL_DIV  = 50000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [2*NUM_CH-1:0]          enc_in,
    input  logic [$clog2(NUM_CH)+1:0]    avs_address,
    input  logic                         avs_read,
    input  logic                         avs_write,
    input  logic [31:0]                  avs_writedata,
    output logic [31:0]                  avs_readdata,
    output logic [NUM_CH-1:0]            dir_out,
    output logic                         err_irq
);

    localparam int               ADDR_W   = $clog2(NUM_CH) + 2;
    localparam int               CH_W     = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam int               TMR_W    = (VEL_DIV > 1) ? $clog2(VEL_DIV) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(VEL_DIV - 1);

    logic [CH_W-1:0]  ch_idx;
    logic [1:0]       reg_sel;
    logic             ch_valid;
    logic [TMR_W-1:0] win_cnt;
    logic             win_tick;
    logic [31:0]      rd_mux;
    logic [CNT_W-1:0] pos_a  [NUM_CH];
    logic [CNT_W-1:0] vel_a  [NUM_CH];
    logic [2:0]       stat_a [NUM_CH];
    logic [2:0]       ctrl_a [NUM_CH];
    logic [NUM_CH-1:0] dir_vec;
    logic [NUM_CH-1:0] irq_vec;

    generate
        if (ADDR_W > 2) begin : g_ch_idx
            assign ch_idx = avs_address[ADDR_W-1:2];
        end else begin : g_ch_single
            assign ch_idx = '0;
        end
    endgenerate

    assign reg_sel  = avs_address[1:0];
    assign ch_valid = ({{(32-CH_W){1'b0}}, ch_idx} < 32'(NUM_CH));
    assign win_tick = (win_cnt == TMR_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt <= '0;
        end else if (win_tick) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + TMR_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = avs_write && ch_valid && (ch_idx == CH_W'(i));

        quad_encoder_channel #(
            .CNT_W    (CNT_W),
            .FILT_LEN (FILT_LEN)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .enc      (enc_in[2*i +: 2]),
            .win_tick (win_tick),
            .pos_we   (sel && (reg_sel == REG_POS)),
            .stat_we  (sel && (reg_sel == REG_STAT)),
            .ctrl_we  (sel && (reg_sel == REG_CTRL)),
            .wdata    (avs_writedata[CNT_W-1:0]),
            .pos      (pos_a[i]),
            .vel      (vel_a[i]),
            .stat     (stat_a[i]),
            .ctrl     (ctrl_a[i])
        );

        assign dir_vec[i] = stat_a[i][STAT_DIR];
        assign irq_vec[i] = stat_a[i][STAT_ERR] & ctrl_a[i][CTRL_IRQ_EN];
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid && (ch_idx == CH_W'(i))) begin
                case (reg_sel)
                    REG_POS:  rd_mux = 32'($signed(pos_a[i]));
                    REG_VEL:  rd_mux = 32'($signed(vel_a[i]));
                    REG_STAT: rd_mux = {29'd0, stat_a[i]};
                    default:  rd_mux = {29'd0, ctrl_a[i]};
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
            dir_out      <= '0;
            err_irq      <= 1'b0;
        end else begin
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
            dir_out <= dir_vec;
            err_irq <= |irq_vec;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_quad_encoder_array : directed bench for quad_encoder_array        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_quad_encoder_array;

    localparam int NUM_CH   = 2;
    localparam int CNT_W    = 8;
    localparam int FILT_LEN = 4;
    localparam int VEL_DIV  = 100;

    logic        clk           = 1'b0;
    logic        reset_n       = 1'b0;
    logic [3:0]  enc_in        = '0;
    logic [2:0]  avs_address   = '0;
    logic        avs_read      = 1'b0;
    logic        avs_write     = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic [1:0]  dir_out;
    logic        err_irq;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int idx [NUM_CH] = '{0, 0};
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    quad_encoder_array #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .FILT_LEN (FILT_LEN),
        .VEL_DIV  (VEL_DIV)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enc_in        (enc_in),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .dir_out       (dir_out),
        .err_irq       (err_irq)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the velocity window ends whenever this hits a multiple of VEL_DIV.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc = 0;
        else          cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic bus_read(input int ch, input int r, output logic [31:0] data);
        avs_address = 3'(ch * 4 + r);
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    task automatic bus_write(input int ch, input int r, input logic [31:0] data);
        avs_address   = 3'(ch * 4 + r);
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic check_reg(input string tag, input int ch, input int r, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(ch, r, d);
        check(tag, d, exp);
    endtask

    task automatic set_pins(input int ch);
        enc_in[2*ch +: 2] = gray[idx[ch]];
    endtask

    task automatic step(input int ch, input bit up, input int hold);
        idx[ch] = (idx[ch] + (up ? 1 : 3)) % 4;
        set_pins(ch);
        repeat (hold) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_readdata", avs_readdata, 32'h0);
        check("rst_dir_out", 32'(dir_out), 32'h0);
        check("rst_err_irq", 32'(err_irq), 32'h0);
        check_reg("rst_pos0", 0, 0, 32'h0);
        check_reg("rst_vel1", 1, 1, 32'h0);
        check_reg("rst_stat0", 0, 2, 32'h0);
        check_reg("rst_ctrl0", 0, 3, 32'h1);

        // 00 -> 11 in one step
        idx[0] = 2;
        set_pins(0);
        repeat (12) @(negedge clk);
        check_reg("illegal_pos", 0, 0, 32'h0);
        check_reg("illegal_stat", 0, 2, 32'h2);
        bus_write(0, 3, 32'h5);
        check("irq_one_cycle_late", 32'(err_irq), 32'h0);
        @(negedge clk);
        check("irq_set", 32'(err_irq), 32'h1);
        bus_write(0, 2, 32'h2);
        @(negedge clk);
        check("irq_cleared", 32'(err_irq), 32'h0);
        check_reg("stat_cleared", 0, 2, 32'h0);

        repeat (40) step(0, 1'b1, 8);
        repeat (10) @(negedge clk);
        check_reg("fwd_pos0", 0, 0, 32'd40);
        check("fwd_dir_out", 32'(dir_out), 32'h1);
        check_reg("fwd_pos1", 1, 0, 32'h0);
        check_reg("fwd_stat0", 0, 2, 32'h1);

        enc_in[2] = 1'b1;
        repeat (3) @(negedge clk);
        enc_in[2] = 1'b0;
        repeat (10) @(negedge clk);
        check_reg("glitch_pos1", 1, 0, 32'h0);
        idx[1] = 1;
        set_pins(1);
        repeat (6) @(negedge clk);
        check_reg("latency_edge7_pre", 1, 0, 32'h0);
        check_reg("latency_edge7_post", 1, 0, 32'h1);

        bus_write(0, 0, 32'd127);
        check_reg("preset_pos0", 0, 0, 32'd127);
        step(0, 1'b1, 8);
        repeat (10) @(negedge clk);
        check_reg("wrap_up_pos", 0, 0, 32'hFFFF_FF80);
        check_reg("wrap_up_stat", 0, 2, 32'h5);
        step(0, 1'b0, 8);
        repeat (10) @(negedge clk);
        check_reg("wrap_dn_pos", 0, 0, 32'h0000_007F);
        check_reg("wrap_dn_stat", 0, 2, 32'h4);
        bus_write(0, 2, 32'h4);
        check_reg("wrap_cleared", 0, 2, 32'h0);

        while (cyc % VEL_DIV != 2) @(negedge clk);
        repeat (25) step(1, 1'b1, 3);
        while (cyc % VEL_DIV != 5) @(negedge clk);
        check_reg("vel_25", 1, 1, 32'd25);
        bus_write(1, 1, 32'd77);
        check_reg("vel_read_only", 1, 1, 32'd25);
        bus_write(1, 0, 32'd1000);
        repeat (5) step(1, 1'b1, 3);
        while (cyc % VEL_DIV != 5) @(negedge clk);
        check_reg("vel_after_preset", 1, 1, 32'd5);
        check_reg("pos_after_preset", 1, 0, 32'hFFFF_FFED);

        bus_write(1, 3, 32'h3);
        step(1, 1'b1, 8);
        repeat (10) @(negedge clk);
        check_reg("invert_pos1", 1, 0, 32'hFFFF_FFEC);
        check_reg("invert_stat1", 1, 2, 32'h0);

        repeat (2) step(0, 1'b1, 8);
        repeat (10) @(negedge clk);
        check_reg("pre_reset_pos0", 0, 0, 32'hFFFF_FF81);
        check("pre_reset_dir_out", 32'(dir_out), 32'h1);
        step(0, 1'b1, 3);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_readdata", avs_readdata, 32'h0);
        check("async_rst_dir_out", 32'(dir_out), 32'h0);
        enc_in = '0;
        idx    = '{0, 0};
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reg("post_rst_pos0", 0, 0, 32'h0);
        check_reg("post_rst_vel1", 1, 1, 32'h0);
        check_reg("post_rst_stat0", 0, 2, 32'h0);
        check_reg("post_rst_ctrl1", 1, 3, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
